counter_arbiter: RTL

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter feeding a shared grant counter.
// Define COUNTER_ARB_SAT_EN for a saturating count that halts at all ones.
module counter_arbiter #(
  parameter int CounterWidth = 32,
  parameter int NumReq       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NumReq-1:0]       req,
  output logic [NumReq-1:0]       gnt,
  output logic                    gnt_valid,
  output logic [CounterWidth-1:0] count,
  output logic                    wrap
);

  localparam int PtrW = $clog2(NumReq);

  localparam logic [CounterWidth-1:0] CntOne =
    {{(CounterWidth-1){1'b0}}, 1'b1};
  localparam logic [CounterWidth-1:0] CntMax = '1;
  localparam logic [PtrW-1:0] PtrRst = PtrW'(NumReq - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_e;

  state_e                  state_q, state_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [NumReq-1:0]       gnt_q, gnt_d;
  logic                    gv_q, gv_d;
  logic [CounterWidth-1:0] count_q, count_d;
  logic                    wrap_q, wrap_d;

  logic                    found;
  logic [PtrW-1:0]         win;
  logic [PtrW-1:0]         idx;

  // Search starts one above the last winner and wraps modulo NumReq.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = 1; k <= NumReq; k++) begin
      idx = PtrW'((int'(ptr_q) + k) % NumReq);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    gnt_d   = '0;
    gv_d    = 1'b0;
    wrap_d  = 1'b0;
    if (clr) begin
      state_d = en ? RUN : IDLE;
      count_d = '0;
    end else if (state_q == HALT) begin
      state_d = HALT;
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      state_d = RUN;
      if (found) begin
        gnt_d   = NumReq'(1) << win;
        gv_d    = 1'b1;
        ptr_d   = win;
        count_d = count_q + CntOne;
`ifdef COUNTER_ARB_SAT_EN
        if (count_q + CntOne == CntMax) begin
          state_d = HALT;
        end
`else
        wrap_d  = (count_q == CntMax);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PtrRst;
      gnt_q   <= '0;
      gv_q    <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      gv_q    <= gv_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gv_q;
  assign count     = count_q;
  assign wrap      = wrap_q;

endmodule
